// File: rtl/alu_serial_ctrl_if.sv
// Request/result handshake bundle for the nibble-serial add/subtract controller.
// The master side issues operands and accepts results; the slave side is the controller.
interface alu_serial_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, y, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, y, carry_out, overflow, busy
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Nibble-serial W-bit add/subtract: one 4-bit slice per RUN cycle, LSB first,
// with a stored carry flag that later operations may chain from.
module alu_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_serial_ctrl_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q, res_q, y_q;
  logic [IW-1:0] idx_q;
  logic          sub_q, carry_q, cmsb_q, cflag_q;
  logic          cout_q, ovf_q, out_valid_q, busy_q;

  logic [IW-1:0] sel;
  logic [3:0]    a_n, b_n;
  logic [4:0]    sum;
  logic          c_msb;

  always_comb begin
    // Index is clamped so the final (bookkeeping) RUN cycle never selects past the operand.
    sel   = (idx_q < LAST) ? idx_q : '0;
    a_n   = a_q[4*sel +: 4];
    b_n   = b_q[4*sel +: 4] ^ {4{sub_q}};
    sum   = {1'b0, a_n} + {1'b0, b_n} + {4'b0, carry_q};
    // Carry into the slice's top bit, recovered from its sum bit.
    c_msb = sum[3] ^ a_n[3] ^ b_n[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cmsb_q      <= 1'b0;
      cflag_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.opcode[0];
            carry_q <= bus.opcode[1] ? cflag_q : bus.opcode[0];
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (idx_q != LAST) begin
            res_q[4*sel +: 4] <= sum[3:0];
            carry_q           <= sum[4];
            cmsb_q            <= c_msb;
            idx_q             <= idx_q + IW'(1);
          end else begin
            // Publish results only now so y keeps its previous value throughout RUN.
            y_q         <= res_q;
            cout_q      <= carry_q;
            ovf_q       <= cmsb_q ^ carry_q;
            cflag_q     <= carry_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES SHALL be derived from it.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  controller can accept a request.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 opcode  input  2  bit0: 1 = subtract (A - B), 0 = add; bit1: 1 = chain carry-in from the stored carry flag, 0 = carry-in = opcode[0].
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 y  output  W  result.
REQ-012 carry_out  output  1  carry out of the MSB slice (for subtract, 1 = no borrow).
REQ-013 overflow  output  1  two's-complement signed overflow of the W-bit operation.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 States SHALL be IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE, in_valid=1: the controller SHALL latch a, b, opcode; latch initial carry = opcode[1] ? carry_flag : opcode[0]; clear the slice index to 0; go to RUN.
REQ-017 RUN: each cycle, one 4-bit slice SHALL compute A[i] + (B[i] XOR {4{opcode[0]}}) + carry.
  - The 4-bit sum goes to y[4i+3:4i]; the slice carry-out is registered as the next carry.
  - Slice order: index 0 (LSB) up to NIBBLES-1.
REQ-018 After slice NIBBLES-1 completes, the state SHALL go to DONE and out_valid SHALL rise; acceptance-to-out_valid latency SHALL be exactly NIBBLES+1 rising edges (5 for the default).
REQ-019 On entry to DONE:
  - carry_out SHALL equal the MSB slice carry.
  - overflow SHALL equal the carry into bit W-1 XOR the carry out of bit W-1.
  - The internal carry_flag SHALL be set to carry_out.
REQ-020 DONE: y, carry_out, overflow and out_valid SHALL hold stable until out_ready=1. On that edge the state SHALL return to IDLE and out_valid SHALL clear.
REQ-021 A new request SHALL NOT be accepted on the same edge as the out_ready handshake; in_ready rises the following cycle.
REQ-022 in_valid, a, b and opcode SHALL be ignored in RUN and DONE; latched operands SHALL NOT change mid-operation.
REQ-023 y SHALL wrap modulo 2^W; no saturation.
REQ-024 carry_flag SHALL change only on entry to DONE. With opcode[1]=1 and no prior completed operation since reset, the chained carry-in SHALL be 0.
REQ-025 y, carry_out and overflow SHALL retain their last DONE values while in IDLE and RUN.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE and clear to 0: y, carry_out, overflow, carry_flag, out_valid, busy and the slice index. in_ready SHALL be 1 while rst_n=0 and after release.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered. The first request after release SHALL behave as if no prior operation had occurred.

Verification
REQ-028 Add: a=0x1234, b=0x0FFF, opcode=00, out_ready=1 -> out_valid 5 edges after acceptance; y=0x2233, carry_out=0, overflow=0.
REQ-029 Subtract with borrow: a=0x0000, b=0x0001, opcode=01 -> y=0xFFFF, carry_out=0, overflow=0. Then a=0x0005, b=0x0003, opcode=01 -> y=0x0002, carry_out=1.
REQ-030 Signed overflow: a=0x7FFF, b=0x0001, opcode=00 -> y=0x8000, overflow=1, carry_out=0. Then a=0x8000, b=0x0001, opcode=01 -> y=0x7FFF, overflow=1, carry_out=1.
REQ-031 Carry chain: a=0xFFFF, b=0x0001, opcode=00 -> y=0x0000, carry_out=1. Then a=0x0000, b=0x0000, opcode=10 -> y=0x0001, carry_out=0.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles after DONE while toggling in_valid, a and b.
  - Required: y and out_valid stable; in_ready=0 throughout; no request accepted.
  - When out_ready=1: out_valid falls; in_ready rises the next cycle.
REQ-033 Reset mid-op: pulse rst_n low 2 cycles into RUN -> all outputs 0 and in_ready=1 immediately. Then a=0x0001, b=0x0001, opcode=10 -> y=0x0002.
